// File: rtl/prefetch_mem_responder_pkg.sv
// rtl/prefetch_mem_responder_pkg.sv - shared types and constants for the prefetch memory responder
//
// Purpose: FSM state encoding, data word width and a helper that sizes the
// latency counter. Imported by the responder top and its request FIFO.
package prefetch_mem_responder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // Counter must hold LAT-1; a latency of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/prefetch_req_fifo.sv
// rtl/prefetch_req_fifo.sv - outstanding read-address queue for the prefetch memory responder
//
// Purpose: synchronous FIFO of word addresses awaiting service.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (empties the queue)
//   push_i   in   enqueue data_i (ignored while full)
//   data_i   in   DATA_W word address
//   pop_i    in   dequeue head (ignored while empty)
//   data_o   out  head entry, valid while !empty_o
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
//   count_o  out  number of stored entries
module prefetch_req_fifo
  import prefetch_mem_responder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push that meets a full queue is dropped even if a pop frees a slot on
  // the same edge; the requester saw wait=1 and will retry.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/prefetch_mem_responder.sv
// rtl/prefetch_mem_responder.sv - responder end of the prefetcher read/write interface
//
// Purpose: queues word reads, services them one at a time with a fixed
// access latency, and absorbs a never-stalled write stream into the same
// backing word store.
// Ports:
//   clk_i         in   clock, rising edge
//   reset_ni      in   asynchronous active-low reset
//   data_req_i    in   read request, accepted when !wait_o
//   r_addr_i      in   byte address; bits [ADDR_W+1:2] select the word
//   wait_o        out  request queue full
//   data_ready_o  out  one-cycle pulse, data_o valid
//   data_o        out  read data, held until the next pulse
//   w_en_i        in   write strobe
//   w_addr_i      in   byte address of write
//   w_data_i      in   write data
module prefetch_mem_responder
  import prefetch_mem_responder_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              data_req_i,
  input  logic [WORD_W-1:0] r_addr_i,
  output logic              wait_o,
  output logic              data_ready_o,
  output logic [WORD_W-1:0] data_o,
  input  logic              w_en_i,
  input  logic [WORD_W-1:0] w_addr_i,
  input  logic [WORD_W-1:0] w_data_i
);

  localparam int CNT_W = cnt_width(LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCNT_W-1:0] FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);

  logic [WORD_W-1:0] store_q [2**ADDR_W];

  logic [ADDR_W-1:0] r_word, w_word, head_addr, cur_addr_q;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] load_data;

  logic              fifo_full, fifo_empty, push, pop;
  logic [FCNT_W-1:0] fifo_count;

  // Upper and byte-offset address bits alias away by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{r_addr_i[WORD_W-1:ADDR_W+2], r_addr_i[1:0],
                              w_addr_i[WORD_W-1:ADDR_W+2], w_addr_i[1:0]};

  assign r_word = r_addr_i[ADDR_W+1:2];
  assign w_word = w_addr_i[ADDR_W+1:2];

  assign wait_o       = (fifo_count == FIFO_FULL_CNT);
  assign data_ready_o = ready_q;
  assign data_o       = data_q;

  assign push = data_req_i && !fifo_full;
  // The FSM takes a new request only when it is between accesses.
  assign pop  = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_RESP));

  // A write landing on the word being loaded this edge wins over the array.
  assign load_data = (w_en_i && (w_word == cur_addr_q)) ? w_data_i : store_q[cur_addr_q];

  prefetch_req_fifo #(
    .DATA_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .push_i  (push),
    .data_i  (r_word),
    .pop_i   (pop),
    .data_o  (head_addr),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Store contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_en_i) begin
      store_q[w_word] <= w_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_addr_q <= '0;
      ready_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cur_addr_q <= head_addr;
            cnt_q      <= CNT_INIT;
            state_q    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            data_q  <= load_data;
            ready_q <= 1'b1;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          ready_q <= 1'b0;
          // Chain straight into the next access to sustain LAT+1 throughput.
          if (pop) begin
            cur_addr_q <= head_addr;
            cnt_q      <= CNT_INIT;
            state_q    <= S_ACCESS;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
